// File: rtl/tawas_dram_arb_if.sv
// Bus bundle for the Tawas data-RAM arbiter: core port A, secondary agent port B
// and the single-ported RAM side. The arbiter uses the slave view.
interface tawas_dram_arb_if #(
    parameter int ADDR_W = 12
);
    logic              a_cs;
    logic              a_wr;
    logic [31:0]       a_addr;
    logic [3:0]        a_mask;
    logic [31:0]       a_wdata;
    logic [31:0]       a_rdata;

    logic              b_req;
    logic              b_wr;
    logic [31:0]       b_addr;
    logic [3:0]        b_mask;
    logic [31:0]       b_wdata;
    logic              b_ready;
    logic              b_rvalid;
    logic [31:0]       b_rdata;
    logic              b_starve;

    logic              m_cs;
    logic              m_wr;
    logic [ADDR_W-1:0] m_addr;
    logic [3:0]        m_mask;
    logic [31:0]       m_wdata;
    logic [31:0]       m_rdata;

    modport slave (
        input  a_cs, a_wr, a_addr, a_mask, a_wdata,
        input  b_req, b_wr, b_addr, b_mask, b_wdata,
        input  m_rdata,
        output a_rdata,
        output b_ready, b_rvalid, b_rdata, b_starve,
        output m_cs, m_wr, m_addr, m_mask, m_wdata
    );

    modport master (
        output a_cs, a_wr, a_addr, a_mask, a_wdata,
        output b_req, b_wr, b_addr, b_mask, b_wdata,
        output m_rdata,
        input  a_rdata,
        input  b_ready, b_rvalid, b_rdata, b_starve,
        input  m_cs, m_wr, m_addr, m_mask, m_wdata
    );
endinterface

// File: rtl/tawas_dram_arb.sv
// Shares one single-ported data RAM between the Tawas core (port A, absolute
// priority, zero added latency) and a buffered secondary agent (port B).
module tawas_dram_arb #(
    parameter int ADDR_W     = 12,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 255
) (
    input logic            clk,
    input logic            rst,
    tawas_dram_arb_if.slave bus
);

    localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

    logic              hold_valid_q, hold_valid_d;
    logic              hold_wr_q,    hold_wr_d;
    logic [ADDR_W-1:0] hold_addr_q,  hold_addr_d;
    logic [3:0]        hold_mask_q,  hold_mask_d;
    logic [31:0]       hold_wdata_q, hold_wdata_d;
    logic [MEM_LAT-1:0] tag_q, tag_d;
    logic [7:0]        wait_q, wait_d;

    logic issue_b_s;
    logic b_ready_s;
    logic accept_s;
    logic unused_s;

    // B may only use the RAM in cycles the core leaves idle; the hold slot can
    // be refilled in the same cycle it drains.
    assign issue_b_s = hold_valid_q && !bus.a_cs;
    assign b_ready_s = !hold_valid_q || issue_b_s;
    assign accept_s  = bus.b_req && b_ready_s;

    assign bus.b_ready  = b_ready_s;
    assign bus.b_rvalid = tag_q[MEM_LAT-1];
    assign bus.b_starve = (wait_q == STARVE_LIM);
    assign bus.a_rdata  = bus.m_rdata;
    assign bus.b_rdata  = bus.m_rdata;

    // Byte-offset and aliasing address bits are intentionally dropped.
    assign unused_s = ^{bus.a_addr[31:ADDR_W+2], bus.a_addr[1:0],
                        bus.b_addr[31:ADDR_W+2], bus.b_addr[1:0]};

    // RAM request mux: port A straight through, otherwise the held B request.
    always_comb begin
        bus.m_cs    = 1'b0;
        bus.m_wr    = 1'b0;
        bus.m_addr  = '0;
        bus.m_mask  = 4'h0;
        bus.m_wdata = 32'h0;
        if (bus.a_cs) begin
            bus.m_cs    = 1'b1;
            bus.m_wr    = bus.a_wr;
            bus.m_addr  = bus.a_addr[ADDR_W+1:2];
            bus.m_mask  = bus.a_mask;
            bus.m_wdata = bus.a_wdata;
        end else if (issue_b_s) begin
            bus.m_cs    = 1'b1;
            bus.m_wr    = hold_wr_q;
            bus.m_addr  = hold_addr_q;
            bus.m_mask  = hold_mask_q;
            bus.m_wdata = hold_wdata_q;
        end else begin
            bus.m_cs    = 1'b0;
        end
    end

    // Hold register next state.
    always_comb begin
        hold_valid_d = accept_s || (hold_valid_q && !issue_b_s);
        if (accept_s) begin
            hold_wr_d    = bus.b_wr;
            hold_addr_d  = bus.b_addr[ADDR_W+1:2];
            hold_mask_d  = bus.b_mask;
            hold_wdata_d = bus.b_wdata;
        end else begin
            hold_wr_d    = hold_wr_q;
            hold_addr_d  = hold_addr_q;
            hold_mask_d  = hold_mask_q;
            hold_wdata_d = hold_wdata_q;
        end
    end

    // Read-return tag pipeline, matched to the RAM read latency.
    always_comb begin
        tag_d    = '0;
        tag_d[0] = issue_b_s && !hold_wr_q;
        for (int i = 1; i < MEM_LAT; i++) begin
            tag_d[i] = tag_q[i-1];
        end
    end

    // Starvation counter: counts cycles the core blocks a pending B request.
    always_comb begin
        if (!hold_valid_q || issue_b_s) begin
            wait_d = 8'd0;
        end else if (bus.a_cs && (wait_q != STARVE_LIM)) begin
            wait_d = wait_q + 8'd1;
        end else begin
            wait_d = wait_q;
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_valid_q <= 1'b0;
            hold_wr_q    <= 1'b0;
            hold_addr_q  <= '0;
            hold_mask_q  <= 4'h0;
            hold_wdata_q <= 32'h0;
            tag_q        <= '0;
            wait_q       <= 8'd0;
        end else begin
            hold_valid_q <= hold_valid_d;
            hold_wr_q    <= hold_wr_d;
            hold_addr_q  <= hold_addr_d;
            hold_mask_q  <= hold_mask_d;
            hold_wdata_q <= hold_wdata_d;
            tag_q        <= tag_d;
            wait_q       <= wait_d;
        end
    end

endmodule

// File: tb/tb_tawas_dram_arb.sv
// Scoreboard bench for tawas_dram_arb: a transaction-level reference model
// predicts RAM requests, handshakes and read returns; a monitor checks them.
module tb_tawas_dram_arb;

    localparam int ADDR_W     = 12;
    localparam int MEM_LAT    = 2;
    localparam int STARVE_MAX = 4;

    typedef struct {
        logic              b_ready;
        logic              b_starve;
        logic              m_cs;
        logic              m_wr;
        logic [ADDR_W-1:0] m_addr;
        logic [3:0]        m_mask;
        logic [31:0]       m_wdata;
    } exp_t;

    typedef struct {
        int          due;
        logic [31:0] data;
    } ret_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail  = 0;

    exp_t expq[$];
    ret_t aq[$];
    ret_t bq[$];

    // Reference model state
    logic [31:0] gmem [0:(1<<ADDR_W)-1];
    logic        pend_v;
    logic        pend_wr;
    int          pend_word;
    logic [3:0]  pend_mask;
    logic [31:0] pend_wdata;
    int          wait_cnt;

    // RAM model state
    logic [31:0] ram [0:(1<<ADDR_W)-1];
    logic [31:0] rd_pipe [0:MEM_LAT-1];

    tawas_dram_arb_if #(.ADDR_W(ADDR_W)) bus ();

    tawas_dram_arb #(
        .ADDR_W(ADDR_W),
        .MEM_LAT(MEM_LAT),
        .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] mask);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) begin
            if (mask[i]) r[i*8 +: 8] = nw[i*8 +: 8];
        end
        return r;
    endfunction

    // Single-ported RAM with MEM_LAT cycles of read latency.
    always @(posedge clk) begin
        if (bus.m_cs && bus.m_wr) ram[bus.m_addr] <= merge(ram[bus.m_addr], bus.m_wdata, bus.m_mask);
        rd_pipe[0] <= ram[bus.m_addr];
        for (int i = 1; i < MEM_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign bus.m_rdata = rd_pipe[MEM_LAT-1];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One cycle of the reference model, using the inputs just applied.
    task automatic model_step();
        exp_t e;
        logic issue;
        int   w;
        e = '{default: '0};
        issue = 1'b0;
        if (rst) begin
            pend_v   = 1'b0;
            wait_cnt = 0;
            bq.delete();
            e.b_ready  = 1'b1;
            e.b_starve = 1'b0;
        end else begin
            issue      = pend_v && !bus.a_cs;
            e.b_ready  = !pend_v || issue;
            e.b_starve = (wait_cnt == STARVE_MAX);
        end
        e.m_cs = bus.a_cs || issue;
        if (bus.a_cs) begin
            w = int'(bus.a_addr[ADDR_W+1:2]);
            e.m_wr = bus.a_wr; e.m_addr = ADDR_W'(w);
            e.m_mask = bus.a_mask; e.m_wdata = bus.a_wdata;
            if (bus.a_wr) gmem[w] = merge(gmem[w], bus.a_wdata, bus.a_mask);
            else aq.push_back('{cyc + MEM_LAT, gmem[w]});
        end else if (issue) begin
            e.m_wr = pend_wr; e.m_addr = ADDR_W'(pend_word);
            e.m_mask = pend_mask; e.m_wdata = pend_wdata;
            if (pend_wr) gmem[pend_word] = merge(gmem[pend_word], pend_wdata, pend_mask);
            else bq.push_back('{cyc + MEM_LAT, gmem[pend_word]});
        end
        if (!rst) begin
            if (!pend_v || issue) wait_cnt = 0;
            else if (bus.a_cs && wait_cnt < STARVE_MAX) wait_cnt = wait_cnt + 1;
            if (bus.b_req && e.b_ready) begin
                pend_v = 1'b1; pend_wr = bus.b_wr; pend_word = int'(bus.b_addr[ADDR_W+1:2]);
                pend_mask = bus.b_mask; pend_wdata = bus.b_wdata;
            end else if (issue) begin
                pend_v = 1'b0;
            end
        end
        expq.push_back(e);
    endtask

    task automatic drive(input logic r, input logic acs, input logic awr, input logic [31:0] aa,
                         input logic [3:0] am, input logic [31:0] ad, input logic breq,
                         input logic bwr, input logic [31:0] ba, input logic [3:0] bm,
                         input logic [31:0] bd);
        @(negedge clk);
        rst = r;
        bus.a_cs = acs; bus.a_wr = awr; bus.a_addr = aa; bus.a_mask = am; bus.a_wdata = ad;
        bus.b_req = breq; bus.b_wr = bwr; bus.b_addr = ba; bus.b_mask = bm; bus.b_wdata = bd;
        #1;
        model_step();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            drive(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    endtask

    task automatic a_rd(input logic [31:0] addr);
        drive(1'b0, 1'b1, 1'b0, addr, 4'hF, 32'h0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    endtask

    task automatic b_rd(input logic [31:0] addr);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 1'b0, addr, 4'hF, 32'h0);
    endtask

    // Monitor: compares each cycle's outputs and pops read returns as they appear.
    initial begin : monitor
        exp_t e;
        ret_t r;
        forever begin
            @(negedge clk);
            #2;
            if (expq.size() > 0) begin
                e = expq.pop_front();
                chk("b_ready",  32'(bus.b_ready),  32'(e.b_ready));
                chk("b_starve", 32'(bus.b_starve), 32'(e.b_starve));
                chk("m_cs",     32'(bus.m_cs),     32'(e.m_cs));
                if (e.m_cs) begin
                    chk("m_wr",    32'(bus.m_wr),   32'(e.m_wr));
                    chk("m_addr",  32'(bus.m_addr), 32'(e.m_addr));
                    chk("m_mask",  32'(bus.m_mask), 32'(e.m_mask));
                    chk("m_wdata", bus.m_wdata,     e.m_wdata);
                end
                if (bus.b_rvalid === 1'b1) begin
                    if (bq.size() == 0) begin
                        chk("b_rvalid_unexpected", 32'(bus.b_rvalid), 32'h0);
                    end else begin
                        r = bq.pop_front();
                        chk("b_rvalid_cycle", 32'(cyc), 32'(r.due));
                        chk("b_rdata", bus.b_rdata, r.data);
                    end
                end else if (bq.size() > 0 && bq[0].due <= cyc) begin
                    r = bq.pop_front();
                    chk("b_rvalid_missing", 32'(bus.b_rvalid), 32'h1);
                end
                if (aq.size() > 0 && aq[0].due <= cyc) begin
                    r = aq.pop_front();
                    chk("a_rdata", bus.a_rdata, r.data);
                end
            end
        end
    end

    initial begin : stimulus
        logic [31:0] aa, ba;
        pend_v = 1'b0; pend_wr = 1'b0; pend_word = 0; pend_mask = 4'h0; pend_wdata = 32'h0;
        wait_cnt = 0;

        // Reset, then prefill the words used by the traffic below.
        for (int i = 0; i < 3; i++)
            drive(1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        for (int w = 0; w < 16; w++)
            drive(1'b0, 1'b1, 1'b1, 32'(w << 2), 4'hF, 32'hA5A5_0000 | 32'(w),
                  1'b0, 1'b0, 32'h0, 4'h0, 32'h0);

        // A-only write then read of 0x40.
        drive(1'b0, 1'b1, 1'b1, 32'h0000_0040, 4'hF, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        a_rd(32'h0000_0040);
        idle(3);

        // B read alone.
        b_rd(32'h0000_0008);
        idle(4);

        // A preempts B for 3 cycles.
        b_rd(32'h0000_000C);
        for (int i = 0; i < 3; i++) a_rd(32'(i << 2));
        idle(4);

        // Starvation: 6 blocking A cycles.
        b_rd(32'h0000_0010);
        for (int i = 0; i < 6; i++) a_rd(32'(i << 2));
        idle(4);

        // Back-to-back B write/read/write/read, then check writes through A.
        drive(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 1'b1, 32'h0000_0020, 4'hF, 32'h1111_2222);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 1'b0, 32'h0000_0024, 4'hF, 32'h0);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 1'b1, 32'h0000_0028, 4'h5, 32'h3333_4444);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 1'b0, 32'h0000_0020, 4'hF, 32'h0);
        idle(4);
        a_rd(32'h0000_0020);
        a_rd(32'h0000_0028);
        idle(3);

        // Reset one cycle after a B read issues.
        b_rd(32'h0000_0004);
        idle(1);
        for (int i = 0; i < 2; i++)
            drive(1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        idle(4);

        // Randomized mixed traffic with aliased addresses and rare resets.
        for (int i = 0; i < 800; i++) begin
            aa = ($urandom() & 32'hFFFF_C000) | 32'($urandom_range(0, 15) << 2) | 32'($urandom_range(0, 3));
            ba = ($urandom() & 32'hFFFF_C000) | 32'($urandom_range(0, 15) << 2) | 32'($urandom_range(0, 3));
            drive(($urandom_range(0, 99) == 0),
                  ($urandom_range(0, 99) < 45), 1'($urandom_range(0, 1)), aa,
                  4'($urandom_range(0, 15)), $urandom(),
                  ($urandom_range(0, 99) < 55), 1'($urandom_range(0, 1)), ba,
                  4'($urandom_range(0, 15)), $urandom());
        end
        idle(6);
        #3;
        chk("b_returns_drained", 32'(bq.size()), 32'h0);
        chk("a_returns_drained", 32'(aq.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/tawas_dram_arb.md
# tawas_dram_arb

Two-port arbiter that shares one single-ported, word-wide data RAM between the Tawas core load/store port (port A) and a secondary bus agent (port B), e.g. an RCN-to-RAM bridge or DMA engine. Port A has absolute priority and sees zero added latency, so core timing is unchanged. Port B is buffered in a one-entry hold register and issued only in cycles where port A is idle. Returning read data is steered to B through a latency-matched tag pipeline. A saturating wait counter flags B starvation.

## Interface
- ADDR_W, 12, memory word-address width; the RAM holds 2^ADDR_W 32-bit words.
- MEM_LAT, 1, RAM read latency in cycles from m_cs to valid m_rdata; legal range 1..4.
- STARVE_MAX, 255, B wait count at which b_starve asserts; legal range 1..255; the counter is 8 bits.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- a_cs, a_wr  in  1  port A select and write strobe.
- a_addr  in  32  port A byte address.
- a_mask  in  4  port A byte enables.
- a_wdata  in  32  port A write data.
- a_rdata  out  32  port A read data, equal to m_rdata.
- b_req, b_wr  in  1  port B request and write strobe.
- b_addr  in  32  port B byte address.
- b_mask  in  4  port B byte enables.
- b_wdata  in  32  port B write data.
- b_ready  out  1  B request accepted on any edge where b_req && b_ready.
- b_rvalid  out  1  one-cycle pulse; b_rdata is valid in that cycle.
- b_rdata  out  32  port B read data, equal to m_rdata.
- b_starve  out  1  high while the B wait counter equals STARVE_MAX.
- m_cs, m_wr  out  1  RAM select and write strobe.
- m_addr  out  ADDR_W  RAM word address.
- m_mask  out  4  RAM byte enables.
- m_wdata  out  32  RAM write data.
- m_rdata  in  32  RAM read data.

## Operation
- Address mapping: word address = addr[ADDR_W+1:2]. Bits [1:0] and bits above ADDR_W+1 are ignored, so addresses alias modulo the RAM size. Lane placement is the requester's job, expressed through mask and data.
- Port A path is purely combinational. When a_cs=1: m_cs=1, and m_wr/m_addr/m_mask/m_wdata come from port A.
- Hold register: hold_valid plus captured wr, addr, mask and wdata. Captured on b_req && b_ready.
- issue_b = hold_valid && !a_cs. When issue_b=1: m_cs=1 and the m_* fields come from the hold register.
- When neither port drives: m_cs=0 and the m_* data fields are don't-care.
- b_ready = !hold_valid || issue_b, so a new B request can refill the hold register in the same cycle it issues.
- Next-state rule: hold_valid' = (b_req && b_ready) || (hold_valid && !issue_b).
- Read tag pipeline: a MEM_LAT-deep shift register, shifting every cycle.
  - Input bit = issue_b && !hold_wr.
  - b_rvalid = the output bit.
- a_rdata and b_rdata are both wired to m_rdata. Port A owns every return slot that is not tagged for B.
- A writes and B writes never collide, because each cycle issues at most one port.
- Wait counter:
  - Cleared when issue_b=1 or hold_valid=0.
  - Otherwise increments each cycle where hold_valid && a_cs, saturating at STARVE_MAX.
  - b_starve = (counter == STARVE_MAX). It is status only and does not change arbitration.

## Timing
- Reset values:
  - hold_valid=0, so b_ready=1 and m_cs=a_cs.
  - Tag pipeline all 0, so b_rvalid=0.
  - Counter 0, so b_starve=0.
  - Hold data fields are don't-care.
- Port A: m_* follow a_* in the same cycle; a_rdata is valid MEM_LAT cycles after a_cs.
- Port B:
  - Request accepted at edge N.
  - Earliest issue is cycle N+1, if a_cs=0 in that cycle.
  - Each cycle with a_cs=1 delays issue by one cycle.
  - Read data: b_rvalid pulses exactly MEM_LAT cycles after the issue cycle.
- Sustained B throughput is one request per cycle while a_cs=0.
- b_ready depends combinationally on a_cs, and b_ready must not feed back into a_cs.
- Reset asserted mid-operation:
  - A held B request is discarded.
  - In-flight B read tags are cleared; no b_rvalid pulse is produced for them, and the B agent must re-issue.
- Outstanding B reads: at most MEM_LAT. The B agent must accept every b_rvalid pulse; there is no backpressure on returns.

## Test plan
- A-only traffic:
  - Stimulus: A writes 0xDEADBEEF to byte address 0x0040 with mask 0xF, then reads the same address.
  - Response: m_addr=0x010 in the same cycle as a_cs; a_rdata=0xDEADBEEF MEM_LAT cycles after the read; b_rvalid stays 0.
- B alone, MEM_LAT=2:
  - Stimulus: B read of byte address 0x0008, accepted at edge N, with a_cs=0.
  - Response: m_cs=1 and m_addr=0x002 in cycle N+1; b_rvalid=1 with correct data in cycle N+3; b_ready stays 1 throughout.
- A preempts B:
  - Stimulus: B request held while a_cs=1 for 3 cycles.
  - Response: b_ready=0 for those 3 cycles; the B issue occurs in the first cycle with a_cs=0; the counter reaches 3, then clears on issue.
- Starvation, STARVE_MAX=4:
  - Stimulus: a_cs=1 for 6 cycles with B pending.
  - Response: b_starve rises after the 4th wait cycle, holds while saturated at 4, and drops the cycle after B issues.
- Back-to-back B traffic:
  - Stimulus: b_req held high for 4 requests (write, read, write, read) with a_cs=0.
  - Response: one issue per cycle; exactly 2 b_rvalid pulses, each MEM_LAT cycles after its read issued; write data is verified later through port A reads.
- Reset mid-flight:
  - Stimulus: assert rst one cycle after a B read issues, with MEM_LAT=2.
  - Response: no b_rvalid pulse; after reset b_ready=1, b_starve=0 and m_cs=a_cs.
